// File: rtl/gpr_file.sv
// gpr_file: 32 x 32-bit register file, two read ports, one debug port, one write port.
// Optional same-cycle write-to-read forwarding when GPR_WRITE_BYPASS_EN is defined.
module gpr_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       write_cnt,
    output logic [7:0]        link_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wen;
    logic              hit1;
    logic              hit2;
    logic              hit_dbg;

    assign wen = reg_write && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            write_cnt <= '0;
            link_cnt  <= '0;
        end else if (wen) begin
            regs[waddr] <= wdata;
            write_cnt   <= write_cnt + 16'd1;
            if (waddr == LINK_ADDR) begin
                link_cnt <= link_cnt + 8'd1;
            end
        end
    end

`ifdef GPR_WRITE_BYPASS_EN
    assign hit1    = wen && (raddr1 == waddr);
    assign hit2    = wen && (raddr2 == waddr);
    assign hit_dbg = wen && (dbg_addr == waddr);
`else
    assign hit1    = 1'b0;
    assign hit2    = 1'b0;
    assign hit_dbg = 1'b0;
`endif

    // Address 0 wins over forwarding so r0 reads zero in every build.
    assign rdata1   = (raddr1 == '0)   ? '0 : hit1    ? wdata : regs[raddr1];
    assign rdata2   = (raddr2 == '0)   ? '0 : hit2    ? wdata : regs[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : hit_dbg ? wdata : regs[dbg_addr];

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: scoreboard bench for gpr_file.
// Expected read/counter values are queued when stimulus is set and compared mid-cycle.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_write = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [15:0] write_cnt;
    logic [7:0]  link_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];

    localparam int S_RD1 = 0;
    localparam int S_RD2 = 1;
    localparam int S_DBG = 2;
    localparam int S_WC  = 3;
    localparam int S_LC  = 4;

    logic [31:0] byp_exp;

    gpr_file dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .write_cnt (write_cnt),
        .link_cnt  (link_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int sel,
                        input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] got;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_RD1:   got = rdata1;
                S_RD2:   got = rdata2;
                S_DBG:   got = dbg_data;
                S_WC:    got = {16'h0, write_cnt};
                default: got = {24'h0, link_cnt};
            endcase
            check(e.tag, got, e.value);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        waddr     = a;
        wdata     = d;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic reads(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] ad);
        raddr1   = a1;
        raddr2   = a2;
        dbg_addr = ad;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset clears a preloaded register and the counters
        wr(5'd5, 32'h1234);
        reads(5'd5, 5'd5, 5'd5);
        push("pre_r5", S_RD1, 32'h1234);
        push("pre_wc", S_WC, 32'd1);
        drain();
        do_reset();
        reads(5'd5, 5'd5, 5'd5);
        push("rst_rd1", S_RD1, 32'h0);
        push("rst_rd2", S_RD2, 32'h0);
        push("rst_dbg", S_DBG, 32'h0);
        push("rst_wc", S_WC, 32'h0);
        push("rst_lc", S_LC, 32'h0);
        drain();

        // basic write then read on all ports
        wr(5'd8, 32'hDEADBEEF);
        reads(5'd8, 5'd8, 5'd8);
        push("r8_rd1", S_RD1, 32'hDEADBEEF);
        push("r8_rd2", S_RD2, 32'hDEADBEEF);
        push("r8_dbg", S_DBG, 32'hDEADBEEF);
        push("r8_wc", S_WC, 32'd1);
        drain();

        // r0 writes are dropped and not counted
        wr(5'd0, 32'hFFFFFFFF);
        reads(5'd0, 5'd0, 5'd0);
        push("r0_rd1", S_RD1, 32'h0);
        push("r0_rd2", S_RD2, 32'h0);
        push("r0_dbg", S_DBG, 32'h0);
        push("r0_wc", S_WC, 32'd1);
        drain();

        // counters hold with reg_write low
        @(posedge clk);
        push("hold_wc", S_WC, 32'd1);
        push("hold_lc", S_LC, 32'd0);
        drain();

        // three jal-style link writes from a clean state
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr(5'd31, 32'h00400008);
        end
        reads(5'd8, 5'd31, 5'd31);
        push("link_rd2", S_RD2, 32'h00400008);
        push("link_dbg", S_DBG, 32'h00400008);
        push("link_r8", S_RD1, 32'h0);
        push("link_lc", S_LC, 32'd3);
        push("link_wc", S_WC, 32'd3);
        drain();

        // same-cycle read and write of r9
        wr(5'd9, 32'h11);
`ifdef GPR_WRITE_BYPASS_EN
        byp_exp = 32'h22;
`else
        byp_exp = 32'h11;
`endif
        reads(5'd9, 5'd9, 5'd9);
        reg_write = 1'b1;
        waddr     = 5'd9;
        wdata     = 32'h22;
        push("rw_rd1", S_RD1, byp_exp);
        push("rw_rd2", S_RD2, byp_exp);
        push("rw_dbg", S_DBG, byp_exp);
        drain();
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        push("rw_next1", S_RD1, 32'h22);
        push("rw_next2", S_RD2, 32'h22);
        drain();

        // forwarding never reaches r0
        reads(5'd0, 5'd0, 5'd0);
        reg_write = 1'b1;
        waddr     = 5'd0;
        wdata     = 32'hABCD;
        push("byp_r0_rd1", S_RD1, 32'h0);
        push("byp_r0_dbg", S_DBG, 32'h0);
        drain();
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        push("byp_r0_wc", S_WC, 32'd5);
        drain();

        // reset beats a simultaneous write
        rst       = 1'b1;
        reg_write = 1'b1;
        waddr     = 5'd3;
        wdata     = 32'h55;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        reg_write = 1'b0;
        reads(5'd3, 5'd9, 5'd3);
        push("rstw_rd1", S_RD1, 32'h0);
        push("rstw_rd2", S_RD2, 32'h0);
        push("rstw_wc", S_WC, 32'h0);
        drain();

        // write counter wrap after 65536 commits
        for (int i = 0; i < 65535; i++) begin
            wr(5'd1, i);
        end
        reads(5'd1, 5'd1, 5'd1);
        push("wc_max", S_WC, 32'hFFFF);
        push("wc_max_rd", S_RD1, 32'd65534);
        drain();
        wr(5'd1, 32'hCAFE0001);
        push("wc_wrap", S_WC, 32'h0);
        push("wc_wrap_lc", S_LC, 32'h0);
        push("wc_wrap_rd", S_RD2, 32'hCAFE0001);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
